lzc_pipe: RTL

//   Parametrised, pipelined leading/trailing zero/one counter with valid/ready handshake.

---
 rtl/lzc_pipe.sv | 131 +++++++++++++
 1 files changed

// File: rtl/lzc_pipe.sv
// Two-stage pipelined leading/trailing zero/one counter with valid/ready handshake.
// Stage 1 holds per-byte summaries; stage 2 holds the registered count, all-flag and tag.
module lzc_pipe #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic [1:0]             in_mode,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(WIDTH):0] out_count,
    output logic                   out_all,
    output logic [TAG_W-1:0]       out_tag
);

    localparam int NG = WIDTH / 8;
    localparam int CW = $clog2(WIDTH) + 1;

    function automatic logic [2:0] byte_lz(input logic [7:0] b);
        logic [2:0] pos;
        logic       hit;
        pos = 3'd0;
        hit = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (!hit && b[i]) begin
                hit = 1'b1;
                pos = 3'(7 - i);
            end
        end
        return pos;
    endfunction

    logic [WIDTH-1:0]       norm;
    logic [NG-1:0]          grp_zero;
    logic [NG-1:0][2:0]     grp_pos;

    logic                   s1_valid;
    logic [NG-1:0]          s1_zero;
    logic [NG-1:0][2:0]     s1_pos;
    logic [TAG_W-1:0]       s1_tag;

    logic                   s2_valid;
    logic [CW-1:0]          s2_count;
    logic                   s2_all;
    logic [TAG_W-1:0]       s2_tag;

    logic                   s1_adv;
    logic                   s2_adv;
    logic                   lead_hit;
    logic [CW-1:0]          lead_count;
    logic                   lead_all;

    // Every mode becomes a leading-zero count: trailing modes reverse, ones modes invert.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            norm[i] = in_mode[0] ? in_data[WIDTH-1-i] : in_data[i];
        end
        if (in_mode[1]) begin
            norm = ~norm;
        end
    end

    always_comb begin
        for (int g = 0; g < NG; g++) begin
            grp_zero[g] = (norm[8*g +: 8] == 8'd0);
            grp_pos[g]  = byte_lz(norm[8*g +: 8]);
        end
    end

    // Handshake: a stage advances when it is empty or the stage after it advances;
    // a transfer happens on a rising edge where valid and ready are both high.
    // in_ready depends combinationally on out_ready (no skid buffer).
    assign s2_adv   = ~s2_valid | out_ready;
    assign s1_adv   = ~s1_valid | s2_adv;
    assign in_ready = s1_adv;

    always_comb begin
        lead_hit   = 1'b0;
        lead_count = CW'(WIDTH);
        lead_all   = 1'b1;
        for (int g = NG - 1; g >= 0; g--) begin
            if (!lead_hit && !s1_zero[g]) begin
                lead_hit   = 1'b1;
                lead_all   = 1'b0;
                lead_count = CW'(8 * (NG - 1 - g)) + CW'(s1_pos[g]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_zero  <= '0;
            s1_pos   <= '0;
            s1_tag   <= '0;
            s2_valid <= 1'b0;
            s2_count <= '0;
            s2_all   <= 1'b0;
            s2_tag   <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_zero <= grp_zero;
                    s1_pos  <= grp_pos;
                    s1_tag  <= in_tag;
                end
            end
            // Result registers only change on a load, so they hold through a stall.
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_count <= lead_count;
                    s2_all   <= lead_all;
                    s2_tag   <= s1_tag;
                end
            end
        end
    end

    assign out_valid = s2_valid;
    assign out_count = s2_count;
    assign out_all   = s2_all;
    assign out_tag   = s2_tag;

endmodule
